// File: rtl/data_bus_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | data_bus_responder                                                        |
// | Core-side data bus target: word RAM with byte/half lanes, console FIFO,   |
// | status flags and a free-running cycle counter in a small MMIO window.     |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module data_bus_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] bus_address,
  input  logic [31:0] bus_wr_data,
  input  logic        bus_wr_enable,
  input  logic [2:0]  bus_write_length,
  output logic [31:0] bus_read_data,
  output logic [7:0]  cons_data,
  output logic        cons_valid,
  input  logic        cons_ready
);

  localparam int c_ADDR_W = $clog2(DEPTH_WORDS);
  localparam int c_PTR_W  = $clog2(FIFO_DEPTH);
  localparam int c_CNT_W  = c_PTR_W + 1;
  localparam logic [c_CNT_W-1:0] c_FULL_CNT = c_CNT_W'(FIFO_DEPTH);

  localparam logic [1:0] c_REG_TXDATA = 2'd0;
  localparam logic [1:0] c_REG_STATUS = 2'd1;
  localparam logic [1:0] c_REG_CYCLES = 2'd2;

  logic [31:0]         r_mem [DEPTH_WORDS];
  logic [7:0]          r_fifo [FIFO_DEPTH];
  logic [c_PTR_W-1:0]  r_wr_ptr;
  logic [c_PTR_W-1:0]  r_rd_ptr;
  logic [c_CNT_W-1:0]  r_count;
  logic                r_overflow;
  logic                r_misalign;
  logic [31:0]         r_cycles;
  logic                r_ram_wr_ok;

  logic                w_is_mmio;
  logic [1:0]          w_reg_sel;
  logic [c_ADDR_W-1:0] w_word_idx;
  logic [31:0]         w_ram_word;
  logic [3:0]          w_lane_mask;
  logic [31:0]         w_lane_data;
  logic                w_len_bad;
  logic                w_ram_st;
  logic                w_ram_we;
  logic                w_misalign_set;
  logic                w_push;
  logic                w_pop;
  logic                w_full;
  logic                w_empty;
  logic                w_push_ok;
  logic                w_overflow_set;
  logic                w_status_wr;
  logic                w_cycles_wr;
  logic [31:0]         w_status;
  logic                w_unused_addr;

  assign w_is_mmio  = bus_address[31];
  assign w_reg_sel  = bus_address[3:2];
  assign w_word_idx = bus_address[c_ADDR_W+1:2];
  assign w_ram_word = r_mem[w_word_idx];
  // Upper address bits above the RAM index simply alias.
  assign w_unused_addr = &{1'b0, bus_address[30:c_ADDR_W+2]};

  always_comb begin
    w_lane_mask = 4'b0000;
    w_lane_data = bus_wr_data;
    w_len_bad   = 1'b0;
    case (bus_write_length)
      3'b000: begin
        w_lane_mask = 4'b0001 << bus_address[1:0];
        w_lane_data = {4{bus_wr_data[7:0]}};
      end
      3'b001: begin
        w_lane_mask = bus_address[1] ? 4'b1100 : 4'b0011;
        w_lane_data = {2{bus_wr_data[15:0]}};
        w_len_bad   = bus_address[0];
      end
      3'b010: begin
        w_lane_mask = 4'b1111;
        w_len_bad   = |bus_address[1:0];
      end
      default: w_len_bad = 1'b1;
    endcase
  end

  assign w_ram_st       = bus_wr_enable & ~w_is_mmio;
  assign w_misalign_set = w_ram_st & w_len_bad;
  assign w_ram_we       = w_ram_st & ~w_len_bad & r_ram_wr_ok;

  // RAM writes are qualified by a flag that is cleared asynchronously, so no
  // store can land while reset is asserted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_ram_wr_ok <= 1'b0;
    else        r_ram_wr_ok <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (w_ram_we) begin
      for (int i = 0; i < 4; i++) begin
        if (w_lane_mask[i]) r_mem[w_word_idx][8*i +: 8] <= w_lane_data[8*i +: 8];
      end
    end
  end

  assign w_push         = bus_wr_enable & w_is_mmio & (w_reg_sel == c_REG_TXDATA);
  assign w_status_wr    = bus_wr_enable & w_is_mmio & (w_reg_sel == c_REG_STATUS);
  assign w_cycles_wr    = bus_wr_enable & w_is_mmio & (w_reg_sel == c_REG_CYCLES);
  assign w_full         = (r_count == c_FULL_CNT);
  assign w_empty        = (r_count == '0);
  assign w_pop          = cons_valid & cons_ready;
  // A pop in the same cycle frees the slot, so a push into a full FIFO is kept.
  assign w_push_ok      = w_push & (~w_full | w_pop);
  assign w_overflow_set = w_push & w_full & ~w_pop;

  always_ff @(posedge clk) begin
    if (w_push_ok) r_fifo[r_wr_ptr] <= bus_wr_data[7:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_misalign <= 1'b0;
      r_cycles   <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
      if (w_pop)     r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
      r_count    <= r_count + c_CNT_W'(w_push_ok) - c_CNT_W'(w_pop);
      r_overflow <= (r_overflow & ~(w_status_wr & bus_wr_data[6])) | w_overflow_set;
      r_misalign <= (r_misalign & ~(w_status_wr & bus_wr_data[7])) | w_misalign_set;
      r_cycles   <= w_cycles_wr ? 32'h0 : r_cycles + 32'h1;
    end
  end

  assign cons_valid = ~w_empty;
  assign cons_data  = cons_valid ? r_fifo[r_rd_ptr] : 8'h00;
  assign w_status   = {24'h0, r_misalign, r_overflow, w_empty, w_full, 4'(r_count)};

  always_comb begin
    bus_read_data = 32'h0;
    if (!w_is_mmio) begin
      bus_read_data = w_ram_word >> {bus_address[1:0], 3'b000};
    end else begin
      case (w_reg_sel)
        c_REG_STATUS: bus_read_data = w_status;
        c_REG_CYCLES: bus_read_data = r_cycles;
        default:      bus_read_data = 32'h0;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_data_bus_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_data_bus_responder                                                     |
// | Directed self-checking bench for data_bus_responder (FIFO_DEPTH = 4).     |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_data_bus_responder;

  localparam logic [31:0] c_TXDATA = 32'h8000_0000;
  localparam logic [31:0] c_STATUS = 32'h8000_0004;
  localparam logic [31:0] c_CYCLES = 32'h8000_0008;
  localparam logic [31:0] c_RSVD   = 32'h8000_000C;

  logic        clk;
  logic        rst_n;
  logic [31:0] bus_address;
  logic [31:0] bus_wr_data;
  logic        bus_wr_enable;
  logic [2:0]  bus_write_length;
  logic [31:0] bus_read_data;
  logic [7:0]  cons_data;
  logic        cons_valid;
  logic        cons_ready;

  int n_cmp;
  int n_bad;

  data_bus_responder #(
    .DEPTH_WORDS(1024),
    .FIFO_DEPTH (4)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .bus_address     (bus_address),
    .bus_wr_data     (bus_wr_data),
    .bus_wr_enable   (bus_wr_enable),
    .bus_write_length(bus_write_length),
    .bus_read_data   (bus_read_data),
    .cons_data       (cons_data),
    .cons_valid      (cons_valid),
    .cons_ready      (cons_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] len);
    @(negedge clk);
    bus_address      = a;
    bus_wr_data      = d;
    bus_write_length = len;
    bus_wr_enable    = 1'b1;
    @(negedge clk);
    bus_wr_enable    = 1'b0;
  endtask

  task automatic load_check(input string tag, input logic [31:0] a, input logic [31:0] exp);
    @(negedge clk);
    bus_address = a;
    #1;
    check(tag, bus_read_data, exp);
  endtask

  initial begin
    n_cmp            = 0;
    n_bad            = 0;
    rst_n            = 1'b0;
    cons_ready       = 1'b0;
    bus_wr_enable    = 1'b0;
    bus_wr_data      = 32'h0;
    bus_write_length = 3'b010;
    bus_address      = c_CYCLES;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check("rst_cons_valid", 32'(cons_valid), 32'h0);
    check("rst_cons_data", 32'(cons_data), 32'h0);
    check("rst_cycles", bus_read_data, 32'h0);
    load_check("rst_status", c_STATUS, 32'h0000_0020);
    @(negedge clk);
    bus_address = c_CYCLES;
    rst_n = 1'b1;
    load_check("cycles_first_edge", c_CYCLES, 32'h1);

    // Lane writes and shifted reads
    store(32'h10, 32'h1122_3344, 3'b010);
    store(32'h11, 32'h0000_00AA, 3'b000);
    load_check("ram_word_after_byte", 32'h10, 32'h1122_AA44);
    load_check("ram_read_shift1", 32'h11, 32'h0011_22AA);
    store(32'h20, 32'h0000_0000, 3'b010);
    store(32'h22, 32'h1234_BEEF, 3'b001);
    load_check("ram_half_upper", 32'h20, 32'hBEEF_0000);
    load_check("ram_read_shift2", 32'h22, 32'h0000_BEEF);
    store(32'h1030, 32'hCAFE_F00D, 3'b010);
    load_check("ram_alias", 32'h30, 32'hCAFE_F00D);

    // Misaligned and illegal-length stores
    store(32'h14, 32'h5566_7788, 3'b010);
    store(32'h13, 32'h0000_FFFF, 3'b001);
    store(32'h16, 32'hDEAD_BEEF, 3'b010);
    load_check("misalign_half_nowrite", 32'h10, 32'h1122_AA44);
    load_check("misalign_word_nowrite", 32'h14, 32'h5566_7788);
    load_check("misalign_flag_set", c_STATUS, 32'h0000_00A0);
    store(c_STATUS, 32'h0000_0080, 3'b010);
    load_check("misalign_flag_clr", c_STATUS, 32'h0000_0020);
    store(32'h10, 32'h0000_0000, 3'b011);
    load_check("badlen_nowrite", 32'h10, 32'h1122_AA44);
    load_check("badlen_flag", c_STATUS, 32'h0000_00A0);
    store(c_STATUS, 32'h0000_00FF, 3'b010);
    store(32'h8000_000D, 32'hFFFF_FFFF, 3'b010);
    load_check("mmio_no_misalign", c_STATUS, 32'h0000_0020);
    load_check("rsvd_reads_zero", c_RSVD, 32'h0);
    load_check("txdata_reads_zero", c_TXDATA, 32'h0);

    // FIFO overflow with sink stalled, then drain in order
    for (int i = 0; i < 5; i++) store(c_TXDATA, 32'h0000_0041 + 32'(i), 3'b010);
    load_check("fifo_full_ovf", c_STATUS, 32'h0000_0054);
    check("fifo_head_valid", 32'(cons_valid), 32'h1);
    check("fifo_head_data", 32'(cons_data), 32'h41);
    @(negedge clk);
    cons_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("fifo_drain", 32'(cons_data), 32'h41 + 32'(i));
      @(negedge clk);
    end
    cons_ready = 1'b0;
    bus_address = c_STATUS;
    #1;
    check("fifo_drained_valid", 32'(cons_valid), 32'h0);
    check("fifo_drained_status", bus_read_data, 32'h0000_0060);
    store(c_STATUS, 32'h0000_0040, 3'b010);
    load_check("ovf_clear", c_STATUS, 32'h0000_0020);

    // Push into full FIFO while popping
    for (int i = 0; i < 4; i++) store(c_TXDATA, 32'h0000_0051 + 32'(i), 3'b000);
    load_check("full_again", c_STATUS, 32'h0000_0014);
    @(negedge clk);
    cons_ready       = 1'b1;
    bus_address      = c_TXDATA;
    bus_wr_data      = 32'h0000_0055;
    bus_write_length = 3'b000;
    bus_wr_enable    = 1'b1;
    @(negedge clk);
    bus_wr_enable = 1'b0;
    cons_ready    = 1'b0;
    bus_address   = c_STATUS;
    #1;
    check("push_pop_full_status", bus_read_data, 32'h0000_0014);
    check("push_pop_full_head", 32'(cons_data), 32'h52);
    @(negedge clk);
    cons_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("push_pop_drain", 32'(cons_data), 32'h52 + 32'(i));
      @(negedge clk);
    end
    cons_ready = 1'b0;
    load_check("push_pop_empty", c_STATUS, 32'h0000_0020);

    // Push and pop together on an empty FIFO
    @(negedge clk);
    cons_ready    = 1'b1;
    bus_address   = c_TXDATA;
    bus_wr_data   = 32'h0000_0066;
    bus_wr_enable = 1'b1;
    @(negedge clk);
    bus_wr_enable = 1'b0;
    #1;
    check("empty_push_valid", 32'(cons_valid), 32'h1);
    check("empty_push_data", 32'(cons_data), 32'h66);
    @(negedge clk);
    #1;
    check("empty_push_popped", 32'(cons_valid), 32'h0);
    cons_ready = 1'b0;

    // Cycle counter clear and wrap
    store(c_CYCLES, 32'h1234_5678, 3'b010);
    repeat (2) @(negedge clk);
    load_check("cycles_after_clear", c_CYCLES, 32'h3);
    @(negedge clk);
    force dut.r_cycles = 32'hFFFF_FFFF;
    #1;
    check("cycles_forced", bus_read_data, 32'hFFFF_FFFF);
    release dut.r_cycles;
    @(negedge clk);
    #1;
    check("cycles_wrap", bus_read_data, 32'h0);

    // Reset mid-transfer
    store(32'h40, 32'h0BAD_F00D, 3'b010);
    for (int i = 0; i < 3; i++) store(c_TXDATA, 32'h0000_0071 + 32'(i), 3'b000);
    #1;
    check("pre_rst_valid", 32'(cons_valid), 32'h1);
    #1;
    rst_n = 1'b0;
    #1;
    check("rst_drop_valid", 32'(cons_valid), 32'h0);
    check("rst_drop_data", 32'(cons_data), 32'h0);
    bus_address = 32'h40;
    #1;
    check("rst_ram_visible", bus_read_data, 32'h0BAD_F00D);
    bus_wr_data      = 32'h1234_5678;
    bus_write_length = 3'b010;
    bus_wr_enable    = 1'b1;
    repeat (2) @(negedge clk);
    bus_wr_enable = 1'b0;
    rst_n = 1'b1;
    load_check("rst_store_ignored", 32'h40, 32'h0BAD_F00D);
    load_check("rst_ram_kept", 32'h10, 32'h1122_AA44);
    load_check("rst_fifo_count", c_STATUS, 32'h0000_0020);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
